// File: rtl/histogram_pkg.sv
// Shared constants, state encoding and saturating-increment helper for the
// histogram actor.
package histogram_pkg;

   localparam int unsigned NUM_BINS    = 256;
   localparam int unsigned BIN_W       = 16;
   localparam int unsigned PIX_W       = 8;
   localparam int unsigned FRAME_CNT_W = 24;

   localparam logic [BIN_W-1:0] BIN_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      CLEAR,
      ACCUM,
      DRAIN,
      EMIT
   } state_t;

   function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] v);
      return (v == BIN_MAX) ? v : v + BIN_W'(1);
   endfunction

endpackage

// File: rtl/histogram_ctrl_if.sv
// Token-protocol bundle between the histogram controller and its upstream
// (In1) and downstream (Out1) actors.
interface histogram_ctrl_if;
   import histogram_pkg::*;

   logic [PIX_W-1:0] In1_DATA;
   logic             In1_SEND;
   logic [15:0]      In1_COUNT;
   logic             In1_ACK;

   logic [BIN_W-1:0] Out1_DATA;
   logic             Out1_SEND;
   logic             Out1_RDY;
   logic             Out1_ACK;
   logic [15:0]      Out1_COUNT;

   logic             FRAME_DONE;

   modport slave (
      input  In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
      output In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT, FRAME_DONE
   );

   modport master (
      output In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
      input  In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT, FRAME_DONE
   );

endinterface

// File: rtl/histogram_bin_ram.sv
// 256x16 simple dual-port bin memory: one write port, one registered read
// port; a same-address read and write returns the old contents.
module histogram_bin_ram
   import histogram_pkg::*;
(
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [PIX_W-1:0] wr_addr_i,
   input  logic [BIN_W-1:0] wr_data_i,
   input  logic [PIX_W-1:0] rd_addr_i,
   output logic [BIN_W-1:0] rd_data_o
);

   logic [BIN_W-1:0] mem_q [NUM_BINS];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/histogram_ctrl.sv
// Frame scheduler: clears the bins, accumulates FRAME_PIXELS pixels with a
// forwarded read-modify-write pipeline, then streams and clears all 256 bins.
module histogram_ctrl
   import histogram_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = 4096
)
(
   input  logic CLK,
   input  logic RESET,
   histogram_ctrl_if.slave bus
);

   localparam logic [FRAME_CNT_W-1:0] LAST_PIX = FRAME_CNT_W'(FRAME_PIXELS - 1);
   localparam logic [PIX_W-1:0]       LAST_BIN = PIX_W'(NUM_BINS - 1);

   state_t                 state_q;
   logic [PIX_W-1:0]       idx_q;
   logic [FRAME_CNT_W-1:0] cnt_q;
   logic                   drain_q;
   logic                   emit_vld_q;
   logic                   done_q;
   logic                   s1_vld_q;
   logic [PIX_W-1:0]       s1_addr_q;
   logic                   lw_vld_q;
   logic [PIX_W-1:0]       lw_addr_q;
   logic [BIN_W-1:0]       lw_data_q;

   logic                   ack;
   logic                   send;
   logic                   wr_en;
   logic [PIX_W-1:0]       wr_addr;
   logic [BIN_W-1:0]       wr_data;
   logic [PIX_W-1:0]       rd_addr;
   logic [BIN_W-1:0]       rd_data;
   logic [BIN_W-1:0]       rmw_base;
   logic                   unused_ok;

   assign ack  = (state_q == ACCUM) && bus.In1_SEND;
   assign send = (state_q == EMIT) && emit_vld_q && bus.Out1_RDY;

   // The RAM returns pre-write data, so a hit on the bin written last cycle
   // must take the freshly written value instead.
   assign rmw_base = (lw_vld_q && (lw_addr_q == s1_addr_q)) ? lw_data_q : rd_data;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = idx_q;
      wr_data = '0;
      rd_addr = idx_q;
      case (state_q)
         CLEAR: wr_en = 1'b1;
         ACCUM, DRAIN: begin
            wr_en   = s1_vld_q;
            wr_addr = s1_addr_q;
            wr_data = sat_inc(rmw_base);
            rd_addr = bus.In1_DATA;
         end
         EMIT: begin
            wr_en = send;
            if (send) rd_addr = idx_q + PIX_W'(1);
         end
         default: ;
      endcase
   end

   histogram_bin_ram u_ram (
      .clk_i     (CLK),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q    <= CLEAR;
         idx_q      <= '0;
         cnt_q      <= '0;
         drain_q    <= 1'b0;
         emit_vld_q <= 1'b0;
         done_q     <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_addr_q  <= '0;
         lw_vld_q   <= 1'b0;
         lw_addr_q  <= '0;
         lw_data_q  <= '0;
      end else begin
         done_q    <= 1'b0;
         s1_vld_q  <= ack;
         s1_addr_q <= bus.In1_DATA;
         lw_vld_q  <= s1_vld_q;
         lw_addr_q <= s1_addr_q;
         lw_data_q <= wr_data;
         case (state_q)
            CLEAR: begin
               idx_q <= idx_q + PIX_W'(1);
               if (idx_q == LAST_BIN) begin
                  state_q <= ACCUM;
                  cnt_q   <= '0;
               end
            end
            ACCUM: begin
               if (ack) begin
                  cnt_q <= cnt_q + FRAME_CNT_W'(1);
                  if (cnt_q == LAST_PIX) begin
                     state_q <= DRAIN;
                     drain_q <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               drain_q <= 1'b1;
               if (drain_q) begin
                  state_q    <= EMIT;
                  idx_q      <= '0;
                  emit_vld_q <= 1'b0;
               end
            end
            EMIT: begin
               emit_vld_q <= 1'b1;
               if (send) begin
                  idx_q <= idx_q + PIX_W'(1);
                  if (idx_q == LAST_BIN) begin
                     state_q    <= ACCUM;
                     cnt_q      <= '0;
                     emit_vld_q <= 1'b0;
                     done_q     <= 1'b1;
                  end
               end
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign bus.In1_ACK    = ack;
   assign bus.Out1_SEND  = send;
   assign bus.Out1_DATA  = emit_vld_q ? rd_data : '0;
   assign bus.Out1_COUNT = 16'h1;
   assign bus.FRAME_DONE = done_q;

   assign unused_ok = ^{bus.In1_COUNT, bus.Out1_ACK};

endmodule

// File: tb/tb_histogram_ctrl.sv
// Self-checking bench: table vectors and random frames on an 8-pixel instance,
// plus a 70000-pixel instance for bin saturation, running in parallel.
module tb_histogram_ctrl;

   logic CLK = 1'b0;
   logic ra, rs;
   always #5 CLK = ~CLK;

   histogram_ctrl_if ifa ();
   histogram_ctrl_if ifs ();

   histogram_ctrl #(.FRAME_PIXELS(8)) u_a (
      .CLK   (CLK),
      .RESET (ra),
      .bus   (ifa)
   );

   histogram_ctrl #(.FRAME_PIXELS(70000)) u_s (
      .CLK   (CLK),
      .RESET (rs),
      .bus   (ifs)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [0:7][7:0]  pix;
      int               rdy_mode;
      int               gap_mode;
      int               n_exp;
      logic [0:3][7:0]  exp_bin;
      logic [0:3][15:0] exp_cnt;
   } vec_t;

   vec_t vecs [6];

   int          exp_h [256];
   logic [15:0] got_q [$];
   int first_ack, last_ack, first_send, done_cnt, done_cyc, bad_send, bad_ack, timeout;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 (after the reset edge when aborting).
   task automatic run_frame(input logic [0:7][7:0] pix, input int rdy_mode,
                            input int gap_mode, input int abort_at);
      int ptr;
      got_q.delete();
      first_ack = -1; last_ack = -1; first_send = -1; done_cnt = 0; done_cyc = -1;
      bad_send = 0; bad_ack = 0; timeout = 1; ptr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         ifa.In1_SEND = (ptr < 8) && (gap_mode == 0 || $urandom_range(0, 2) != 0);
         ifa.In1_DATA = (ptr < 8) ? pix[ptr] : 8'($urandom);
         case (rdy_mode)
            0:       ifa.Out1_RDY = 1'b1;
            1:       ifa.Out1_RDY = (cyc % 2 == 0);
            default: ifa.Out1_RDY = 1'($urandom_range(0, 1));
         endcase
         @(negedge CLK);
         if (ifa.In1_ACK && !ifa.In1_SEND) bad_ack++;
         if (first_ack >= 0 && ptr < 8 && ifa.In1_ACK != ifa.In1_SEND) bad_ack++;
         if (ifa.In1_ACK) begin
            if (first_ack < 0) first_ack = cyc;
            last_ack = cyc;
            ptr++;
         end
         if (ifa.Out1_SEND) begin
            if (!ifa.Out1_RDY) bad_send++;
            if (first_send < 0) first_send = cyc;
            got_q.push_back(ifa.Out1_DATA);
         end
         if (ifa.FRAME_DONE) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (abort_at >= 0 && ifa.Out1_SEND && got_q.size() == abort_at + 1) begin
            ra = 1'b0;
            timeout = 0;
            break;
         end
         if (done_cyc >= 0) begin
            timeout = 0;
            break;
         end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
   endtask

   task automatic check_frame(input string tag, input int rdy_mode, input bit after_reset);
      int mism, first_bad;
      longint g;
      check({tag, " timeout"}, timeout, 0);
      check({tag, " token_count"}, got_q.size(), 256);
      mism = 0; first_bad = -1;
      for (int i = 0; i < 256; i++) begin
         g = (i < got_q.size()) ? longint'(got_q[i]) : -1;
         if (g != exp_h[i]) begin
            mism++;
            if (first_bad < 0) first_bad = i;
         end
      end
      check($sformatf("%s wrong_bins(first bin %0d)", tag, first_bad), mism, 0);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " send_while_not_rdy"}, bad_send, 0);
      check({tag, " ack_vs_send"}, bad_ack, 0);
      if (rdy_mode == 0) begin
         check({tag, " first_send_latency"}, first_send - last_ack, 4);
         check({tag, " emit_length"}, done_cyc - first_send, 256);
      end
      if (after_reset) check({tag, " first_ack_cycle"}, first_ack, 256);
   endtask

   task automatic load_vec_exp(input int v);
      for (int i = 0; i < 256; i++) exp_h[i] = 0;
      for (int j = 0; j < vecs[v].n_exp; j++) exp_h[vecs[v].exp_bin[j]] = int'(vecs[v].exp_cnt[j]);
   endtask

   task automatic test_a();
      int n;
      logic [0:7][7:0] pix;
      logic [7:0] base;
      int rm, gm;

      vecs[0] = '{pix: {8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd255}, rdy_mode: 0, gap_mode: 0,
                  n_exp: 3, exp_bin: {8'd0, 8'd5, 8'd255, 8'd0}, exp_cnt: {16'd1, 16'd5, 16'd2, 16'd0}};
      vecs[1] = '{pix: {8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd255}, rdy_mode: 1, gap_mode: 0,
                  n_exp: 3, exp_bin: {8'd0, 8'd5, 8'd255, 8'd0}, exp_cnt: {16'd1, 16'd5, 16'd2, 16'd0}};
      vecs[2] = '{pix: {8{8'd3}}, rdy_mode: 0, gap_mode: 0,
                  n_exp: 1, exp_bin: {8'd3, 8'd0, 8'd0, 8'd0}, exp_cnt: {16'd8, 16'd0, 16'd0, 16'd0}};
      vecs[3] = '{pix: {8{8'd9}}, rdy_mode: 0, gap_mode: 0,
                  n_exp: 1, exp_bin: {8'd9, 8'd0, 8'd0, 8'd0}, exp_cnt: {16'd8, 16'd0, 16'd0, 16'd0}};
      vecs[4] = '{pix: {8'd200, 8'd201, 8'd200, 8'd201, 8'd200, 8'd201, 8'd200, 8'd201}, rdy_mode: 2,
                  gap_mode: 0, n_exp: 2, exp_bin: {8'd200, 8'd201, 8'd0, 8'd0},
                  exp_cnt: {16'd4, 16'd4, 16'd0, 16'd0}};
      vecs[5] = '{pix: {8'd10, 8'd11, 8'd10, 8'd12, 8'd10, 8'd11, 8'd12, 8'd10}, rdy_mode: 0,
                  gap_mode: 1, n_exp: 3, exp_bin: {8'd10, 8'd11, 8'd12, 8'd0},
                  exp_cnt: {16'd4, 16'd2, 16'd2, 16'd0}};

      // Reset with a pending pixel.
      ra = 1'b0;
      ifa.In1_SEND = 1'b1; ifa.In1_DATA = 8'd0; ifa.In1_COUNT = 16'h55;
      ifa.Out1_RDY = 1'b1; ifa.Out1_ACK = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset In1_ACK", ifa.In1_ACK, 0);
      check("reset Out1_SEND", ifa.Out1_SEND, 0);
      check("reset Out1_DATA", ifa.Out1_DATA, 0);
      check("reset FRAME_DONE", ifa.FRAME_DONE, 0);
      check("reset Out1_COUNT", ifa.Out1_COUNT, 1);
      @(posedge CLK); #1;
      ra = 1'b1;
      n = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge CLK);
         if (ifa.In1_ACK) begin
            n = c;
            break;
         end
         @(posedge CLK); #1;
      end
      check("first ack after reset", n, 256);

      // Abort ACCUM right after one pixel was taken; it must not leak into the next frame.
      @(posedge CLK); #1;
      ifa.In1_SEND = 1'b0;
      ra = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      ra = 1'b1;

      for (int v = 0; v < 6; v++) begin
         load_vec_exp(v);
         run_frame(vecs[v].pix, vecs[v].rdy_mode, vecs[v].gap_mode, -1);
         check_frame($sformatf("vec%0d", v), vecs[v].rdy_mode, v == 0);
      end

      for (int f = 0; f < 8; f++) begin
         base = 8'($urandom);
         for (int k = 0; k < 8; k++) pix[k] = base + 8'($urandom_range(0, 3));
         for (int i = 0; i < 256; i++) exp_h[i] = 0;
         for (int k = 0; k < 8; k++) if (exp_h[pix[k]] < 65535) exp_h[pix[k]]++;
         rm = $urandom_range(0, 2);
         gm = $urandom_range(0, 1);
         run_frame(pix, rm, gm, -1);
         check_frame($sformatf("rand%0d", f), rm, 1'b0);
      end

      // Reset in the middle of EMIT.
      run_frame({8{8'd4}}, 0, 0, 100);
      check("abort tokens before reset", got_q.size(), 101);
      @(negedge CLK);
      check("abort Out1_SEND after reset edge", ifa.Out1_SEND, 0);
      check("abort Out1_DATA after reset edge", ifa.Out1_DATA, 0);
      check("abort FRAME_DONE after reset edge", ifa.FRAME_DONE, 0);
      @(posedge CLK); #1;
      ra = 1'b1;
      for (int i = 0; i < 256; i++) exp_h[i] = 0;
      exp_h[1] = 8;
      run_frame({8{8'd1}}, 0, 0, -1);
      check_frame("post_abort", 0, 1'b1);
   endtask

   task automatic test_s();
      int acks, nz;
      bit fin;
      logic [15:0] tok [$];
      rs = 1'b0;
      ifs.In1_SEND = 1'b1; ifs.In1_DATA = 8'd7; ifs.In1_COUNT = 16'h0;
      ifs.Out1_RDY = 1'b1; ifs.Out1_ACK = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      rs = 1'b1;
      acks = 0; fin = 1'b0;
      for (int c = 0; c < 72000; c++) begin
         @(negedge CLK);
         if (ifs.In1_ACK) acks++;
         if (ifs.Out1_SEND) tok.push_back(ifs.Out1_DATA);
         if (ifs.FRAME_DONE) begin
            fin = 1'b1;
            break;
         end
         @(posedge CLK); #1;
         if (acks >= 70000) ifs.In1_SEND = 1'b0;
      end
      check("sat frame completed", fin, 1);
      check("sat pixels accepted", acks, 70000);
      check("sat token_count", tok.size(), 256);
      check("sat bin7", (tok.size() > 7) ? longint'(tok[7]) : -1, 65535);
      nz = 0;
      for (int i = 0; i < tok.size(); i++) if (i != 7 && tok[i] != 16'd0) nz++;
      check("sat nonzero other bins", nz, 0);
   endtask

   initial begin
      fork
         test_a();
         test_s();
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
